// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit-port arbiter.
// The optional idle-lock timeout is enabled with UART_ARB_LOCK_TIMEOUT_EN.
package uart_tx_arbiter_pkg;

   typedef enum logic [1:0] {
      ST_READY    = 2'd0,
      ST_WRITE    = 2'd1,
      ST_GAP      = 2'd2,
      ST_WAIT_RDY = 2'd3
   } arb_state_t;

   localparam int GAP_W = 4;
   localparam int TO_W  = 16;

   // Modulo-n increment of a requester index.
   function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
      return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_picker.sv
// Combinational round-robin first-one search: the first set request at or
// above ptr, wrapping past N-1.
module uart_rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          any
);

   // Scan N positions starting at ptr; the first hit wins.
   always_comb begin
      int  j;
      logic hit;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      j     = 0;
      hit   = 1'b0;
      for (int k = 0; k < N; k++) begin
         j = k + int'(ptr);
         j = (j >= N) ? (j - N) : j;
         hit = !any && req[IW'(j)];
         grant[IW'(j)] = hit;
         idx = hit ? IW'(j) : idx;
         any = any | hit;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locked sharing of one UART byte-write port with TXRDY pacing.
// Optional idle-lock timeout and sticky LOCK_TO flag: define UART_ARB_LOCK_TIMEOUT_EN.
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int NUM_REQ      = 4,
   parameter int IDLE_GAP     = 2,
   parameter int LOCK_TIMEOUT = 255
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [NUM_REQ-1:0]   REQ_VALID,
   input  logic [8*NUM_REQ-1:0] REQ_DATA,
   input  logic [NUM_REQ-1:0]   REQ_LAST,
   output logic [NUM_REQ-1:0]   REQ_READY,
   input  logic                 TXRDY,
   output logic                 UART_CSN,
   output logic                 UART_WEN,
   output logic [7:0]           UART_DATA,
   output logic [NUM_REQ-1:0]   GRANT,
`ifdef UART_ARB_LOCK_TIMEOUT_EN
   output logic                 LOCK_TO,
`endif
   output logic                 BUSY
);

   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   if (NUM_REQ < 2 || NUM_REQ > 8 || IDLE_GAP < 1 || IDLE_GAP > 15 ||
       LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > 65535) begin : g_param_err
      $error("uart_tx_arbiter: parameter out of range");
   end

   arb_state_t         state_r, state_s;
   logic               locked_r, locked_s;
   logic [IW-1:0]      owner_r, owner_s, rr_ptr_r, rr_ptr_s;
   logic [NUM_REQ-1:0] grant_r, grant_s;
   logic [GAP_W-1:0]   gap_cnt_r, gap_cnt_s;
   logic               csn_r, csn_s, wen_r, wen_s, busy_r, busy_s;
   logic [7:0]         data_r, data_s;

   logic [NUM_REQ-1:0] pick_grant_s, ready_s;
   logic [IW-1:0]      pick_idx_s, win_idx_s;
   logic               pick_any_s, xfer_s, last_s, to_hit_s;
   logic [7:0]         byte_s;

   uart_rr_picker #(.N(NUM_REQ), .IW(IW)) u_picker (
      .req   (REQ_VALID),
      .ptr   (rr_ptr_r),
      .grant (pick_grant_s),
      .idx   (pick_idx_s),
      .any   (pick_any_s)
   );

   // Accept path: only the lock owner, or the round-robin winner, may be ready.
   always_comb begin
      ready_s   = '0;
      win_idx_s = owner_r;
      if (state_r == ST_READY) begin
         if (locked_r) begin
            ready_s[owner_r] = 1'b1;
            win_idx_s        = owner_r;
         end else begin
            ready_s   = pick_any_s ? pick_grant_s : '0;
            win_idx_s = pick_idx_s;
         end
      end else begin
         ready_s = '0;
      end
      xfer_s = |(ready_s & REQ_VALID);
      byte_s = REQ_DATA[{win_idx_s, 3'b000} +: 8];
      last_s = REQ_LAST[win_idx_s];
   end

`ifdef UART_ARB_LOCK_TIMEOUT_EN
   logic [TO_W-1:0] to_cnt_r;
   logic            lock_to_r, idle_s;

   assign idle_s   = (state_r == ST_READY) && locked_r && !REQ_VALID[owner_r];
   assign to_hit_s = idle_s && (to_cnt_r == TO_W'(LOCK_TIMEOUT - 1));
   assign LOCK_TO  = lock_to_r;

   // Idle-lock cycle counter and sticky timeout flag.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         to_cnt_r  <= '0;
         lock_to_r <= 1'b0;
      end else begin
         if (xfer_s || to_hit_s) begin
            to_cnt_r <= '0;
         end else if (idle_s) begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end else begin
            to_cnt_r <= to_cnt_r;
         end
         if (xfer_s && last_s) begin
            lock_to_r <= 1'b0;
         end else if (to_hit_s) begin
            lock_to_r <= 1'b1;
         end else begin
            lock_to_r <= lock_to_r;
         end
      end
   end
`else
   assign to_hit_s = 1'b0;
`endif

   // Next-state and registered-output logic of the write-pacing FSM.
   always_comb begin
      state_s   = state_r;
      locked_s  = locked_r;
      owner_s   = owner_r;
      grant_s   = grant_r;
      rr_ptr_s  = rr_ptr_r;
      gap_cnt_s = gap_cnt_r;
      csn_s     = 1'b1;
      wen_s     = 1'b1;
      data_s    = data_r;
      case (state_r)
         ST_READY: begin
            if (xfer_s) begin
               state_s  = ST_WRITE;
               csn_s    = 1'b0;
               wen_s    = 1'b0;
               data_s   = byte_s;
               owner_s  = win_idx_s;
               grant_s  = NUM_REQ'(1) << win_idx_s;
               locked_s = !last_s;
               rr_ptr_s = last_s ? IW'(wrap_inc(32'(win_idx_s), NUM_REQ)) : rr_ptr_r;
            end else if (to_hit_s) begin
               locked_s = 1'b0;
               grant_s  = '0;
               rr_ptr_s = IW'(wrap_inc(32'(owner_r), NUM_REQ));
            end else begin
               state_s = ST_READY;
            end
         end
         ST_WRITE: begin
            // The strobe cycle itself is the first ignored TXRDY cycle.
            state_s   = (IDLE_GAP > 1) ? ST_GAP : ST_WAIT_RDY;
            gap_cnt_s = GAP_W'(IDLE_GAP - 1);
            grant_s   = locked_r ? grant_r : '0;
         end
         ST_GAP: begin
            gap_cnt_s = (gap_cnt_r == '0) ? '0 : (gap_cnt_r - GAP_W'(1));
            state_s   = (gap_cnt_r <= GAP_W'(1)) ? ST_WAIT_RDY : ST_GAP;
         end
         ST_WAIT_RDY: begin
            state_s = TXRDY ? ST_READY : ST_WAIT_RDY;
         end
         default: begin
            state_s = ST_WAIT_RDY;
         end
      endcase
      busy_s = (state_s != ST_READY) || locked_s;
   end

   // State and output registers; reset drops any in-flight byte.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_r   <= ST_WAIT_RDY;
         locked_r  <= 1'b0;
         owner_r   <= '0;
         grant_r   <= '0;
         rr_ptr_r  <= '0;
         gap_cnt_r <= '0;
         csn_r     <= 1'b1;
         wen_r     <= 1'b1;
         data_r    <= 8'h00;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_s;
         locked_r  <= locked_s;
         owner_r   <= owner_s;
         grant_r   <= grant_s;
         rr_ptr_r  <= rr_ptr_s;
         gap_cnt_r <= gap_cnt_s;
         csn_r     <= csn_s;
         wen_r     <= wen_s;
         data_r    <= data_s;
         busy_r    <= busy_s;
      end
   end

   assign REQ_READY = ready_s;
   assign UART_CSN  = csn_r;
   assign UART_WEN  = wen_r;
   assign UART_DATA = data_r;
   assign GRANT     = grant_r;
   assign BUSY      = busy_r;

endmodule
